// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the branch predictor: FSM encoding,
// 2-bit counter values, BTB entry layout and the sequential-PC increment.
package branch_pred_pkg;

  localparam int BTB_TAG_BITS = 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    logic                    jmp_bit;
    logic [1:0]              cnt;
  } btb_entry_t;

  function automatic logic [1:0] cnt_sat(input logic [1:0] cnt, input logic up);
    if (up) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_unit_if.sv
// Fetch lookup, EX resolution, redirect and performance-counter signals
// between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_unit_if;

  logic [31:0] IF_PC;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;

  logic        STALL;
  logic        EX_VALID;
  logic        EX_JUMP;
  logic        EX_BRANCH;
  logic [31:0] EX_PC;
  logic        EX_PRED_TAKEN;
  logic [31:0] EX_PRED_TARGET;
  logic        EX_TAKEN;
  logic [31:0] EX_TARGET;

  logic        FLUSH;
  logic [31:0] REDIRECT_PC;
  logic        BUSY;
  logic [31:0] BRANCH_COUNT;
  logic [31:0] MISPRED_COUNT;

  modport master (
    output IF_PC, STALL, EX_VALID, EX_JUMP, EX_BRANCH, EX_PC,
           EX_PRED_TAKEN, EX_PRED_TARGET, EX_TAKEN, EX_TARGET,
    input  PRED_TAKEN, PRED_TARGET, FLUSH, REDIRECT_PC, BUSY,
           BRANCH_COUNT, MISPRED_COUNT
  );

  modport slave (
    input  IF_PC, STALL, EX_VALID, EX_JUMP, EX_BRANCH, EX_PC,
           EX_PRED_TAKEN, EX_PRED_TARGET, EX_TAKEN, EX_TARGET,
    output PRED_TAKEN, PRED_TARGET, FLUSH, REDIRECT_PC, BUSY,
           BRANCH_COUNT, MISPRED_COUNT
  );

endinterface

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: asynchronous fetch read, asynchronous read of the
// EX entry for the counter update, and one synchronous write port.
module btb_array
  import branch_pred_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  CLK,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output btb_entry_t            rd_entry,
  input  logic [INDEX_BITS-1:0] upd_idx,
  output btb_entry_t            upd_entry,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  btb_entry_t            wr_entry
);

  btb_entry_t mem [2**INDEX_BITS];

  // No reset on the array: the INIT sweep clears every entry after reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry  = mem[rd_idx];
  assign upd_entry = mem[upd_idx];

endmodule

// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: BTB lookup for fetch, table update and registered
// flush/redirect on EX resolution, plus branch/mispredict counters.
//   state   | meaning
//   ST_INIT | sweeping the BTB to invalid/WNT, BUSY=1, resolutions ignored
//   ST_RUN  | predicting and updating until the next RESET
module branch_predictor_unit
  import branch_pred_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = BTB_TAG_BITS
) (
  input logic                     CLK,
  input logic                     RESET,
  branch_predictor_unit_if.slave  bp
);

  logic [0:0]              state;
  logic [INDEX_BITS-1:0]   init_idx;
  logic                    run;

  btb_entry_t              rd_entry;
  btb_entry_t              upd_entry;
  btb_entry_t              wr_entry;
  logic                    wr_en;
  logic [INDEX_BITS-1:0]   wr_idx;

  logic [INDEX_BITS-1:0]   if_idx;
  logic [INDEX_BITS-1:0]   ex_idx;
  logic [BTB_TAG_BITS-1:0] if_tag;
  logic [BTB_TAG_BITS-1:0] ex_tag;
  logic                    if_hit;
  logic                    ex_hit;
  logic                    pred_taken;
  logic                    res;
  logic                    mispred;

  logic                    flush;
  logic [31:0]             redirect_pc;
  logic [31:0]             branch_count;
  logic [31:0]             mispred_count;

  assign run    = (state == ST_RUN);
  assign if_idx = bp.IF_PC[INDEX_BITS+1:2];
  assign ex_idx = bp.EX_PC[INDEX_BITS+1:2];
  assign if_tag = BTB_TAG_BITS'(bp.IF_PC[INDEX_BITS+2 +: TAG_BITS]);
  assign ex_tag = BTB_TAG_BITS'(bp.EX_PC[INDEX_BITS+2 +: TAG_BITS]);

  btb_array #(.INDEX_BITS(INDEX_BITS)) u_btb (
    .CLK       (CLK),
    .rd_idx    (if_idx),
    .rd_entry  (rd_entry),
    .upd_idx   (ex_idx),
    .upd_entry (upd_entry),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_entry  (wr_entry)
  );

  // Lookup reads the array before this cycle's write lands.
  assign if_hit     = rd_entry.valid & (rd_entry.tag == if_tag);
  assign pred_taken = run & if_hit & (rd_entry.jmp_bit | (rd_entry.cnt >= CNT_WT));

  assign bp.PRED_TAKEN  = pred_taken;
  assign bp.PRED_TARGET = pred_taken ? rd_entry.target : bp.IF_PC + PC_INC;

  assign ex_hit  = upd_entry.valid & (upd_entry.tag == ex_tag);
  assign res     = run & bp.EX_VALID & (bp.EX_JUMP | bp.EX_BRANCH) & ~bp.STALL & ~flush;
  assign mispred = (bp.EX_TAKEN != bp.EX_PRED_TAKEN) |
                   (bp.EX_TAKEN & (bp.EX_TARGET != bp.EX_PRED_TARGET));

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = init_idx;
    wr_entry = '0;
    if (!run) begin
      wr_en    = 1'b1;
      wr_entry = '{valid: 1'b0, tag: '0, target: '0, jmp_bit: 1'b0, cnt: CNT_WNT};
    end else if (res) begin
      wr_idx = ex_idx;
      if (bp.EX_TAKEN) begin
        wr_en            = 1'b1;
        wr_entry.valid   = 1'b1;
        wr_entry.tag     = ex_tag;
        wr_entry.target  = bp.EX_TARGET;
        wr_entry.jmp_bit = bp.EX_JUMP;
        if (ex_hit) begin
          wr_entry.cnt = cnt_sat(upd_entry.cnt, 1'b1);
        end else begin
          wr_entry.cnt = bp.EX_JUMP ? CNT_ST : CNT_WT;
        end
      end else if (ex_hit) begin
        wr_en        = 1'b1;
        wr_entry     = upd_entry;
        wr_entry.cnt = cnt_sat(upd_entry.cnt, 1'b0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == {INDEX_BITS{1'b1}}) begin
        state <= ST_RUN;
      end
    end
  end

  // Flush lasts one cycle: res is masked while flush is high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      branch_count  <= '0;
      mispred_count <= '0;
    end else begin
      flush <= res & mispred;
      if (res) begin
        branch_count <= branch_count + 32'd1;
        if (mispred) begin
          mispred_count <= mispred_count + 32'd1;
          redirect_pc   <= bp.EX_TAKEN ? bp.EX_TARGET : bp.EX_PC + PC_INC;
        end
      end
    end
  end

  assign bp.FLUSH         = flush;
  assign bp.REDIRECT_PC   = redirect_pc;
  assign bp.BUSY          = ~run;
  assign bp.BRANCH_COUNT  = branch_count;
  assign bp.MISPRED_COUNT = mispred_count;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit: directed scenarios plus random
// traffic checked against a table-level reference model.
module tb_branch_predictor_unit;

  logic CLK = 1'b0;
  logic RESET;

  branch_predictor_unit_if bp();

  branch_predictor_unit #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bp    (bp)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: one record per table slot, plus architectural registers.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  bit          m_jmp    [64];
  int          m_cnt    [64];
  int          m_init_left;
  bit          m_flush;
  logic [31:0] m_redirect;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  typedef struct {
    bit          pred_taken;
    logic [31:0] pred_target;
    bit          busy;
    bit          flush;
    logic [31:0] redirect;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_init_left = 64;
    m_flush     = 1'b0;
    m_redirect  = '0;
    m_bcnt      = '0;
    m_mcnt      = '0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int idx;
    int unsigned tag;
    idx = int'(pc[7:2]);
    tag = int'(pc[15:8]);
    t = (m_init_left == 0) && m_valid[idx] && (m_tag[idx] == tag) && (m_jmp[idx] || m_cnt[idx] >= 2);
    tgt = t ? m_target[idx] : pc + 32'd4;
  endfunction

  function automatic void model_update();
    bit res, mis, hit;
    int idx;
    int unsigned tag;
    if (RESET) begin
      model_reset();
      return;
    end
    if (m_init_left > 0) begin
      m_init_left--;
      m_flush = 1'b0;
      return;
    end
    res = bp.EX_VALID && (bp.EX_JUMP || bp.EX_BRANCH) && !bp.STALL && !m_flush;
    m_flush = 1'b0;
    if (!res) return;
    idx = int'(bp.EX_PC[7:2]);
    tag = int'(bp.EX_PC[15:8]);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    mis = (bp.EX_TAKEN != bp.EX_PRED_TAKEN) || (bp.EX_TAKEN && bp.EX_TARGET != bp.EX_PRED_TARGET);
    m_bcnt = m_bcnt + 1;
    if (mis) begin
      m_mcnt     = m_mcnt + 1;
      m_flush    = 1'b1;
      m_redirect = bp.EX_TAKEN ? bp.EX_TARGET : bp.EX_PC + 32'd4;
    end
    if (bp.EX_TAKEN) begin
      m_cnt[idx]    = hit ? ((m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1) : (bp.EX_JUMP ? 3 : 2);
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tag;
      m_target[idx] = bp.EX_TARGET;
      m_jmp[idx]    = bp.EX_JUMP;
    end else if (hit) begin
      m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
    end
  endfunction

  // Push the expectation for this cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    bit pt;
    logic [31:0] ptg;
    model_predict(bp.IF_PC, pt, ptg);
    e.pred_taken  = pt;
    e.pred_target = ptg;
    e.busy        = (m_init_left > 0);
    e.flush       = m_flush;
    e.redirect    = m_redirect;
    e.bcnt        = m_bcnt;
    e.mcnt        = m_mcnt;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    model_update();
  endtask

  task automatic set_idle(input logic [31:0] ifpc);
    bp.IF_PC     = ifpc;
    bp.EX_VALID  = 1'b0;
    bp.EX_JUMP   = 1'b0;
    bp.EX_BRANCH = 1'b0;
    bp.STALL     = 1'b0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input bit jump, input bit taken,
                        input logic [31:0] target, input bit stall);
    bit pt;
    logic [31:0] ptg;
    model_predict(pc, pt, ptg);
    bp.EX_VALID       = 1'b1;
    bp.EX_JUMP        = jump;
    bp.EX_BRANCH      = !jump;
    bp.EX_PC          = pc;
    bp.EX_TAKEN       = taken;
    bp.EX_TARGET      = target;
    bp.STALL          = stall;
    bp.EX_PRED_TAKEN  = pt;
    bp.EX_PRED_TARGET = ptg;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (bp.BUSY === 1'b1 && n < 100) begin
      bp.IF_PC = $urandom;
      tick();
      n++;
    end
    cmp(name, n, 64);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("sb_pred_taken",  bp.PRED_TAKEN,    e.pred_taken);
        cmp("sb_pred_target", bp.PRED_TARGET,   e.pred_target);
        cmp("sb_busy",        bp.BUSY,          e.busy);
        cmp("sb_flush",       bp.FLUSH,         e.flush);
        cmp("sb_redirect",    bp.REDIRECT_PC,   e.redirect);
        cmp("sb_branch_cnt",  bp.BRANCH_COUNT,  e.bcnt);
        cmp("sb_mispred_cnt", bp.MISPRED_COUNT, e.mcnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RESET             = 1'b1;
    bp.IF_PC          = '0;
    bp.STALL          = 1'b0;
    bp.EX_VALID       = 1'b0;
    bp.EX_JUMP        = 1'b0;
    bp.EX_BRANCH      = 1'b0;
    bp.EX_PC          = '0;
    bp.EX_PRED_TAKEN  = 1'b0;
    bp.EX_PRED_TARGET = '0;
    bp.EX_TAKEN       = 1'b0;
    bp.EX_TARGET      = '0;
    @(posedge CLK);
    #1;
    model_reset();
    tick();
    tick();
    cmp("reset_busy", bp.BUSY, 1);
    cmp("reset_flush", bp.FLUSH, 0);

    // 1: init sweep length, then empty table never predicts taken.
    RESET = 1'b0;
    wait_init("init_busy_cycles");
    for (int i = 0; i < 8; i++) begin
      set_idle($urandom);
      tick();
    end

    // 2: BEQ 0x100 taken to 0x80, predicted not-taken.
    set_ex(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
    tick();
    cmp("t2_flush", bp.FLUSH, 1);
    cmp("t2_redirect", bp.REDIRECT_PC, 32'h80);
    cmp("t2_mispred", bp.MISPRED_COUNT, 1);
    set_idle(32'h100);
    #1;
    cmp("t2_pred_taken", bp.PRED_TAKEN, 1);
    cmp("t2_pred_target", bp.PRED_TARGET, 32'h80);
    tick();
    cmp("t2_flush_pulse", bp.FLUSH, 0);

    // 3: not-taken twice, second one predicted taken by the pipe.
    set_ex(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    bp.EX_PRED_TAKEN  = 1'b0;
    bp.EX_PRED_TARGET = 32'h104;
    tick();
    cmp("t3_no_flush", bp.FLUSH, 0);
    set_ex(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    bp.EX_PRED_TAKEN  = 1'b1;
    bp.EX_PRED_TARGET = 32'h80;
    tick();
    cmp("t3_flush", bp.FLUSH, 1);
    cmp("t3_redirect", bp.REDIRECT_PC, 32'h104);
    set_idle(32'h100);
    #1;
    cmp("t3_pred_taken", bp.PRED_TAKEN, 0);
    tick();

    // 4: JAL 0x200 -> 0x400, first stalled, then resolved.
    set_ex(32'h200, 1'b1, 1'b1, 32'h400, 1'b1);
    tick();
    cmp("t4_stall_flush", bp.FLUSH, 0);
    cmp("t4_stall_bcnt", bp.BRANCH_COUNT, 3);
    cmp("t4_stall_mcnt", bp.MISPRED_COUNT, 2);
    set_idle(32'h200);
    #1;
    cmp("t4_stall_pred", bp.PRED_TAKEN, 0);
    set_ex(32'h200, 1'b1, 1'b1, 32'h400, 1'b0);
    tick();
    cmp("t4_bcnt", bp.BRANCH_COUNT, 4);
    cmp("t4_redirect", bp.REDIRECT_PC, 32'h400);
    set_idle(32'h200);
    #1;
    cmp("t4_pred_taken", bp.PRED_TAKEN, 1);
    cmp("t4_pred_target", bp.PRED_TARGET, 32'h400);
    tick();

    // 5: wrong-path EX during FLUSH is ignored; reset drops a pending flush.
    set_ex(32'h300, 1'b0, 1'b1, 32'h500, 1'b0);
    tick();
    cmp("t5_flush", bp.FLUSH, 1);
    set_ex(32'h304, 1'b0, 1'b1, 32'h600, 1'b0);
    tick();
    cmp("t5_ignored_bcnt", bp.BRANCH_COUNT, 5);
    cmp("t5_ignored_flush", bp.FLUSH, 0);
    set_ex(32'h308, 1'b0, 1'b1, 32'h700, 1'b0);
    RESET = 1'b1;
    tick();
    cmp("t5_rst_flush", bp.FLUSH, 0);
    cmp("t5_rst_bcnt", bp.BRANCH_COUNT, 0);
    cmp("t5_rst_mcnt", bp.MISPRED_COUNT, 0);
    cmp("t5_rst_busy", bp.BUSY, 1);
    RESET = 1'b0;
    set_idle(32'h0);
    wait_init("reinit_busy_cycles");

    // 6: aliasing 0x100 / 0x4100 share index 0 with different tags.
    set_ex(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
    tick();
    set_idle(32'h0);
    tick();
    set_ex(32'h4100, 1'b0, 1'b1, 32'h900, 1'b0);
    tick();
    set_idle(32'h100);
    #1;
    cmp("t6_evicted_taken", bp.PRED_TAKEN, 0);
    cmp("t6_evicted_target", bp.PRED_TARGET, 32'h104);
    bp.IF_PC = 32'h4100;
    #1;
    cmp("t6_new_taken", bp.PRED_TAKEN, 1);
    cmp("t6_new_target", bp.PRED_TARGET, 32'h900);
    tick();

    // Random traffic over a small PC pool so hits, aliasing and saturation occur.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      logic [31:0] tgt;
      bit jump;
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      tgt = ($urandom_range(0, 15) << 4);
      jump = ($urandom_range(0, 4) == 0);
      set_ex(pc, jump, jump ? 1'b1 : 1'($urandom_range(0, 1)), tgt, ($urandom_range(0, 7) == 0));
      bp.EX_VALID = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        bp.EX_JUMP   = 1'b0;
        bp.EX_BRANCH = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        bp.EX_PRED_TAKEN  = 1'($urandom_range(0, 1));
        bp.EX_PRED_TARGET = ($urandom_range(0, 15) << 4);
      end
      bp.IF_PC = ($urandom_range(0, 3) == 0) ? $urandom
                 : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
      RESET = ($urandom_range(0, 999) == 0);
      tick();
    end
    RESET = 1'b0;
    set_idle(32'h0);
    tick();

    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    #1;
    cmp("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
